// File: rtl/spi_byte_receiver_pkg.sv
// Shared types and default parameters for the SPI byte receiver.
//
// Contents:
//   rx_state_t          - receive FSM state: IDLE (waiting for a frame) / SHIFT (in a frame)
//   SPI_RX_DATA_WIDTH   - default bits per SPI word
//   SPI_RX_FIFO_DEPTH   - default receive buffer depth (power of two, >= 2)
//   SPI_RX_SYNC_STAGES  - default synchronizer depth per SPI input (>= 2)
//   spi_rx_assemble()   - places one wire bit into a partially assembled 8-bit word

package spi_byte_receiver_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int unsigned SPI_RX_DATA_WIDTH  = 8;
  localparam int unsigned SPI_RX_FIFO_DEPTH  = 4;
  localparam int unsigned SPI_RX_SYNC_STAGES = 2;

  // Reference helper for the default 8-bit word: shifts one wire bit into an
  // accumulating word in either bit order. The receiver itself uses the
  // width-generic form of the same rule.
  function automatic logic [7:0] spi_rx_assemble(input logic [7:0] word,
                                                 input logic       bit_in,
                                                 input logic       msb_first);
    logic [7:0] res;
    if (msb_first) begin
      res = {word[6:0], bit_in};
    end else begin
      res = {bit_in, word[7:1]};
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//
// Ports:
//   clk_in   - clock
//   reset    - synchronous, active-high; empties the FIFO
//   wr_en    - push request; honoured when not full, or when full and a pop
//              happens in the same cycle
//   wr_data  - word to push
//   rd_en    - pop request; ignored while empty
//   rd_data  - head word, valid while empty=0
//   empty    - no words stored
//   full     - DEPTH words stored
//
// A push that is not honoured is silently dropped; the caller detects that
// case (wr_en & full & ~pop) itself.

module sync_fifo
  import spi_byte_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_RX_DATA_WIDTH,
  parameter int unsigned DEPTH = SPI_RX_FIFO_DEPTH
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = rd_en & ~empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = wr_en & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap naturally.
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 slave receiver in the clk_in domain.
//
// Oversamples spi_clk/spi_cs/spi_mosi through per-input synchronizers,
// deserializes words on synchronized SCK rising edges while CS is low, and
// buffers completed words in a FWFT FIFO handed out over valid/ready.
//
// Ports:
//   clk_in        - system clock
//   reset         - synchronous, active-high
//   spi_clk       - SPI SCK (asynchronous)
//   spi_cs        - SPI chip select, active-low (asynchronous)
//   spi_mosi      - SPI data in (asynchronous)
//   byte_out      - FIFO head word, zero while byte_valid=0
//   byte_valid    - FIFO non-empty
//   byte_ready    - consumer accepts the head word
//   frame_active  - synchronized CS is low
//   frame_end     - one-cycle pulse on synchronized CS rising edge
//   overflow      - sticky: a completed word was dropped on a full FIFO
//
// SCK high and low phases must each last at least two clk_in cycles.

module spi_byte_receiver
  import spi_byte_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_RX_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH  = SPI_RX_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = SPI_RX_SYNC_STAGES,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  frame_active,
  output logic                  frame_end,
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam int unsigned SetW = $clog2(SYNC_STAGES + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, cs_rise;

  assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame arming
  // ---------------------------------------------------------------------------
  // The synchronizers reset to "CS high", which hides the real pin for
  // SYNC_STAGES cycles. A frame is only accepted once CS has been observed
  // high from real pin samples, so a frame already in progress at reset is
  // ignored until CS goes high and low again.
  logic [SetW-1:0] settle_q, settle_d;
  logic            settled;
  logic            armed_q, armed_d;

  assign settled  = (settle_q == SetW'(SYNC_STAGES));
  assign settle_d = settled ? settle_q : settle_q + SetW'(1);
  assign armed_d  = armed_q | (settled & cs_s);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  rx_state_t state_q, state_d;
  logic      cnt_clr;
  logic      shift_en;
  logic      word_done;

  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shift_next;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !cs_s) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A partial word is simply abandoned; IDLE clears the bit count.
        if (cs_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
      end
      SHIFT: begin
        if (!cs_s && sck_rise) begin
          shift_en  = 1'b1;
          word_done = (bit_cnt_q == LastBit);
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------------
  assign shift_next = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, shift_q[DATA_WIDTH-1:1]};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (cnt_clr) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d   = shift_next;
      // Wrap to 0 and keep shifting: back-to-back words need no CS toggle.
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive buffer and overflow flag
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  overflow_q, overflow_d;

  // The completed word is pushed in the same cycle as its final SCK edge.
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .wr_en   (word_done),
    .wr_data (shift_next),
    .rd_en   (byte_ready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign pop        = byte_ready & ~fifo_empty;
  assign overflow_d = overflow_q | (word_done & fifo_full & ~pop);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_valid   = ~fifo_empty;
  assign byte_out     = fifo_empty ? '0 : fifo_rd_data;
  assign frame_active = ~cs_s;
  assign frame_end    = cs_rise;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Scoreboard bench for spi_byte_receiver. A bus-functional SPI master drives
// mode-0 frames; a reference model decides which words the receiver must
// deliver (4-deep buffer, drop-on-full unless a pop coincides) and queues
// them. An independent monitor pops and compares on every accepted byte.

module tb_spi_byte_receiver;

  localparam int unsigned Depth = 4;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_active;
  logic       frame_end;
  logic       overflow;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         exp_fe = 0;
  int         fe_cnt = 0;

  // 0: ready low, 1: ready high, 2: random ready
  int         ready_mode = 0;
  logic       rnd_ready = 1'b1;

  always #5 clk_in = ~clk_in;

  assign byte_ready = (ready_mode == 1) || ((ready_mode == 2) && rnd_ready);

  spi_byte_receiver #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (Depth),
    .SYNC_STAGES (2),
    .MSB_FIRST   (1'b1)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .frame_active (frame_active),
    .frame_end    (frame_end),
    .overflow     (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random ready, never low for more than 3 cycles in a row.
  initial begin
    int low_run = 0;
    forever begin
      @(posedge clk_in);
      #1;
      if (low_run >= 3) rnd_ready = 1'b1;
      else rnd_ready = 1'($urandom_range(0, 1));
      low_run = rnd_ready ? 0 : low_run + 1;
    end
  end

  // Monitor: compare every accepted byte and the hold-while-stalled rule.
  initial begin
    logic       hold = 1'b0;
    logic [7:0] hold_byte = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(byte_valid), 32'd1);
          check("hold_data", 32'(byte_out), 32'(hold_byte));
        end
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %02h want none at %0t", byte_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(byte_out), 32'(e));
          end
        end
        hold      = byte_valid && !byte_ready;
        hold_byte = byte_out;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (frame_end) fe_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a word is delivered if the 4-deep buffer has room or a
  // pop lands in the same cycle; otherwise it is lost and overflow sticks.
  task automatic model_word(input logic [7:0] d, input bit concurrent_pop);
    if (exp_q.size() < Depth || concurrent_pop) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic set_ready(input int m);
    @(posedge clk_in);
    #1;
    ready_mode = m;
  endtask

  // One mode-0 bit; optional ready pulse exactly on the push cycle.
  task automatic spi_bit(input logic b, input bit pulse);
    @(negedge clk_in);
    spi_mosi = b;
    @(negedge clk_in);
    @(negedge clk_in);
    spi_clk = 1'b1;
    repeat (2) @(posedge clk_in);
    if (pulse) begin
      #1;
      ready_mode = 1;
    end
    @(posedge clk_in);
    if (pulse) begin
      #1;
      ready_mode = 0;
    end
    @(negedge clk_in);
    spi_clk = 1'b0;
  endtask

  task automatic spi_word(input logic [7:0] d, input bit pulse_last);
    model_word(d, pulse_last);
    for (int i = 7; i >= 0; i--) spi_bit(d[i], pulse_last && (i == 0));
  endtask

  task automatic spi_partial(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) spi_bit(d[7-i], 1'b0);
  endtask

  task automatic cs_low();
    @(negedge clk_in);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk_in);
    check("frame_active_hi", 32'(frame_active), 32'd1);
  endtask

  task automatic cs_high();
    @(negedge clk_in);
    spi_cs = 1'b1;
    exp_fe++;
    repeat (6) @(negedge clk_in);
    check("frame_active_lo", 32'(frame_active), 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    set_ready(1);
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d left want 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk_in);
    check({name, "_valid_after"}, 32'(byte_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_byte_out"}, 32'(byte_out), 32'd0);
    check({name, "_valid"}, 32'(byte_valid), 32'd0);
    check({name, "_frame_active"}, 32'(frame_active), 32'd0);
    check({name, "_frame_end"}, 32'(frame_end), 32'd0);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    reset    = 1'b1;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("rst");
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk_in);

    // Single word
    set_ready(1);
    cs_low();
    spi_word(8'hA5, 1'b0);
    cs_high();
    drain("single");
    check("single_ovf", 32'(overflow), 32'(exp_ovf));
    check("single_fe", 32'(fe_cnt), 32'(exp_fe));

    // Burst into a stalled consumer, then drain in order
    set_ready(0);
    cs_low();
    for (int i = 1; i <= 4; i++) spi_word(8'(i), 1'b0);
    cs_high();
    check("burst_valid", 32'(byte_valid), 32'd1);
    check("burst_head", 32'(byte_out), 32'h01);
    drain("burst");
    check("burst_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a pop on exactly the fifth push cycle
    set_ready(0);
    cs_low();
    for (int i = 0; i < 4; i++) spi_word(8'($urandom), 1'b0);
    spi_word(8'($urandom), 1'b1);
    cs_high();
    check("simul_ovf", 32'(overflow), 32'd0);
    drain("simul");
    check("simul_ovf_after", 32'(overflow), 32'(exp_ovf));

    // Abort after 5 bits, then a clean frame
    set_ready(1);
    cs_low();
    spi_partial(8'hFF, 5);
    cs_high();
    check("abort_valid", 32'(byte_valid), 32'd0);
    check("abort_fe", 32'(fe_cnt), 32'(exp_fe));
    cs_low();
    spi_word(8'h3C, 1'b0);
    cs_high();
    drain("abort_next");

    // Randomized traffic: random data, frame splits, aborts and ready
    set_ready(2);
    cs_low();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        spi_partial(8'($urandom), $urandom_range(1, 7));
        cs_high();
        cs_low();
      end else begin
        spi_word(8'($urandom), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin
        cs_high();
        cs_low();
      end
    end
    cs_high();
    drain("random");
    check("random_fe", 32'(fe_cnt), 32'(exp_fe));
    check("random_ovf", 32'(overflow), 32'(exp_ovf));

    // Overflow: five words into a stalled 4-deep buffer
    set_ready(0);
    cs_low();
    for (int i = 0; i < 5; i++) spi_word(8'(8'h10 + i), 1'b0);
    cs_high();
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-word with a stored word and overflow pending
    set_ready(0);
    cs_low();
    spi_word(8'h77, 1'b0);
    spi_partial(8'hC3, 3);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("midrst");
    // Rest of the interrupted frame, plus a full word's worth: all ignored
    w = 8'($urandom);
    spi_partial(8'h18, 5);
    spi_partial(w, 8);
    repeat (4) @(negedge clk_in);
    check("midrst_ignored", 32'(byte_valid), 32'd0);
    cs_high();
    set_ready(1);
    cs_low();
    spi_word(8'h5A, 1'b0);
    cs_high();
    drain("midrst_next");
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("final_fe", 32'(fe_cnt), 32'(exp_fe));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
